// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS control FSM with configurable memory latency and EPC-based traps.
// Owns no data; decodes opcode/funct into datapath strobes and mux selects.
module mc_control_unit #(
    parameter int MEM_LAT = 1,
    parameter bit OVF_EXC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       overflow_i,
    input  logic       zero_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic       PCWrite_o,
    output logic       memRW_o,
    output logic       IRWrite_o,
    output logic       RegWrite_o,
    output logic       ABWrite_o,
    output logic       AluOutWrite_o,
    output logic       EpcWrite_o,
    output logic [2:0] aluOP_o,
    output logic [2:0] muxIord_o,
    output logic [1:0] muxAluSrcA_o,
    output logic [1:0] muxAluSrcB_o,
    output logic [2:0] muxRegDst_o,
    output logic [2:0] muxMemToReg_o,
    output logic [2:0] muxPCSource_o,
    output logic [1:0] excCode_o
);
    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE, S_REGREAD, S_EX_R, S_WB_R, S_EX_I, S_WB_I, S_BR,
        S_ADDR, S_MEM_RD, S_WB_LD, S_MEM_WR, S_JR, S_RTE, S_J, S_JAL, S_EXC
    } state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] exc_q, exc_d;
    logic       mem_done;
    // Counter restarts on every state change, so it only ever counts memory-wait cycles.
    assign mem_done  = cnt_q == 4'(MEM_LAT - 1);
    assign cnt_d     = (state_d == state_q) ? cnt_q + 4'd1 : 4'd0;
    assign excCode_o = exc_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            cnt_q   <= 4'd0;
            exc_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
        end
    end
    always_comb begin
        state_d       = state_q;
        exc_d         = exc_q;
        PCWrite_o     = 1'b0;
        memRW_o       = 1'b0;
        IRWrite_o     = 1'b0;
        RegWrite_o    = 1'b0;
        ABWrite_o     = 1'b0;
        AluOutWrite_o = 1'b0;
        EpcWrite_o    = 1'b0;
        aluOP_o       = 3'b000;
        muxIord_o     = 3'b000;
        muxAluSrcA_o  = 2'b00;
        muxAluSrcB_o  = 2'b00;
        muxRegDst_o   = 3'b000;
        muxMemToReg_o = 3'b000;
        muxPCSource_o = 3'b000;
        case (state_q)
            S_RESET: begin
                RegWrite_o  = 1'b1;
                muxRegDst_o = 3'b100;
                state_d     = S_FETCH;
            end
            S_FETCH: state_d = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                muxAluSrcB_o  = 2'b01;
                aluOP_o       = 3'b001;
                muxPCSource_o = 3'b001;
                PCWrite_o     = 1'b1;
                IRWrite_o     = 1'b1;
                state_d       = S_REGREAD;
            end
            S_REGREAD: begin
                ABWrite_o     = 1'b1;
                muxAluSrcB_o  = 2'b11;
                aluOP_o       = 3'b001;
                AluOutWrite_o = 1'b1;
                case (opcode_i)
                    6'h00: case (funct_i)
                        6'h20, 6'h22, 6'h24: state_d = S_EX_R;
                        6'h08: state_d = S_JR;
                        6'h13: state_d = S_RTE;
                        default: begin
                            state_d = S_EXC;
                            exc_d   = 2'b01;
                        end
                    endcase
                    6'h08, 6'h09: state_d = S_EX_I;
                    6'h04, 6'h05: state_d = S_BR;
                    6'h23, 6'h2B: state_d = S_ADDR;
                    6'h02: state_d = S_J;
                    6'h03: state_d = S_JAL;
                    default: begin
                        state_d = S_EXC;
                        exc_d   = 2'b01;
                    end
                endcase
            end
            S_EX_R: begin
                muxAluSrcA_o  = 2'b10;
                aluOP_o       = (funct_i == 6'h22) ? 3'b010 : (funct_i == 6'h24) ? 3'b011 : 3'b001;
                AluOutWrite_o = 1'b1;
                state_d       = S_WB_R;
                if (overflow_i && OVF_EXC && funct_i != 6'h24) begin
                    state_d = S_EXC;
                    exc_d   = 2'b10;
                end
            end
            S_WB_R: begin
                RegWrite_o    = 1'b1;
                muxRegDst_o   = 3'b010;
                muxMemToReg_o = 3'b110;
                state_d       = S_FETCH;
            end
            S_EX_I: begin
                muxAluSrcA_o  = 2'b10;
                muxAluSrcB_o  = 2'b10;
                aluOP_o       = 3'b001;
                AluOutWrite_o = 1'b1;
                state_d       = S_WB_I;
                if (overflow_i && OVF_EXC && opcode_i == 6'h08) begin
                    state_d = S_EXC;
                    exc_d   = 2'b10;
                end
            end
            S_WB_I: begin
                RegWrite_o    = 1'b1;
                muxMemToReg_o = 3'b110;
                state_d       = S_FETCH;
            end
            S_BR: begin
                muxAluSrcA_o  = 2'b10;
                aluOP_o       = 3'b010;
                muxPCSource_o = 3'b010;
                PCWrite_o     = (opcode_i == 6'h04 && zero_i) || (opcode_i == 6'h05 && !zero_i);
                state_d       = S_FETCH;
            end
            S_ADDR: begin
                muxAluSrcA_o  = 2'b10;
                muxAluSrcB_o  = 2'b10;
                aluOP_o       = 3'b001;
                AluOutWrite_o = 1'b1;
                state_d       = (opcode_i == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                muxIord_o = 3'b001;
                state_d   = mem_done ? S_WB_LD : S_MEM_RD;
            end
            S_WB_LD: begin
                RegWrite_o    = 1'b1;
                muxMemToReg_o = 3'b001;
                state_d       = S_FETCH;
            end
            S_MEM_WR: begin
                muxIord_o = 3'b001;
                memRW_o   = 1'b1;
                state_d   = mem_done ? S_FETCH : S_MEM_WR;
            end
            S_JR: begin
                muxAluSrcA_o  = 2'b10;
                muxPCSource_o = 3'b001;
                PCWrite_o     = 1'b1;
                state_d       = S_FETCH;
            end
            S_RTE: begin
                muxPCSource_o = 3'b101;
                PCWrite_o     = 1'b1;
                state_d       = S_FETCH;
            end
            S_J: begin
                muxPCSource_o = 3'b110;
                PCWrite_o     = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                RegWrite_o    = 1'b1;
                muxRegDst_o   = 3'b011;
                muxMemToReg_o = 3'b011;
                state_d       = S_J;
            end
            S_EXC: begin
                EpcWrite_o    = 1'b1;
                muxAluSrcB_o  = 2'b01;
                aluOP_o       = 3'b010;
                muxPCSource_o = 3'b100;
                PCWrite_o     = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: three parameterisations driven by directed and random instruction streams,
// each cycle compared against a per-instruction recipe of expected control vectors.
module tb_mc_control_unit;
    typedef struct packed {
        logic       pcw, mrw, irw, rgw, abw, aow, epw;
        logic [2:0] alu, iord;
        logic [1:0] sa, sb;
        logic [2:0] rd, m2r, pcs;
        logic [1:0] exc;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_v [3];
    logic [5:0] op_v  [3];
    logic [5:0] fn_v  [3];
    logic       ov_v  [3];
    logic       z_v   [3];
    ctl_t       obs   [3];
    logic [1:0] exc_m [3];
    ctl_t       q [$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        logic       pcw, mrw, irw, rgw, abw, aow, epw;
        logic [2:0] alu, iord, rd, m2r, pcs;
        logic [1:0] sa, sb, exc;
        mc_control_unit #(.MEM_LAT(g == 0 ? 1 : (g == 1 ? 3 : 2)), .OVF_EXC(g != 2)) dut (
            .clk(clk), .rst(rst_v[g]), .overflow_i(ov_v[g]), .zero_i(z_v[g]),
            .opcode_i(op_v[g]), .funct_i(fn_v[g]),
            .PCWrite_o(pcw), .memRW_o(mrw), .IRWrite_o(irw), .RegWrite_o(rgw),
            .ABWrite_o(abw), .AluOutWrite_o(aow), .EpcWrite_o(epw), .aluOP_o(alu),
            .muxIord_o(iord), .muxAluSrcA_o(sa), .muxAluSrcB_o(sb), .muxRegDst_o(rd),
            .muxMemToReg_o(m2r), .muxPCSource_o(pcs), .excCode_o(exc)
        );
        assign obs[g] = {pcw, mrw, irw, rgw, abw, aow, epw, alu, iord, sa, sb, rd, m2r, pcs, exc};
    end

    function automatic int lat(int k);
        return k == 0 ? 1 : (k == 1 ? 3 : 2);
    endfunction

    function automatic bit ovfen(int k);
        return k != 2;
    endfunction

    function automatic ctl_t v(int k, int pcw, int mrw, int irw, int rgw, int abw, int aow, int epw,
                               int alu, int iord, int sa, int sb, int rd, int m2r, int pcs);
        return {1'(pcw), 1'(mrw), 1'(irw), 1'(rgw), 1'(abw), 1'(aow), 1'(epw),
                3'(alu), 3'(iord), 2'(sa), 2'(sb), 3'(rd), 3'(m2r), 3'(pcs), exc_m[k]};
    endfunction

    task automatic chk(string tag, ctl_t o, ctl_t e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, o, e);
        end
    endtask

    task automatic trap(int k, logic [1:0] cause);
        exc_m[k] = cause;
        q.push_back(v(k, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 0, 4));
    endtask

    // Expected per-cycle vectors for one instruction, from fetch through its last cycle.
    task automatic build(int k, logic [5:0] op, logic [5:0] fn, bit ov, bit z);
        int l = lat(k);
        repeat (l) q.push_back(v(k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(v(k, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
        q.push_back(v(k, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3, 0, 0, 0));
        if (op == 0 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            q.push_back(v(k, 0, 0, 0, 0, 0, 1, 0, fn == 6'h20 ? 1 : (fn == 6'h22 ? 2 : 3), 0, 2, 0, 0, 0, 0));
            if (ov && ovfen(k) && fn != 6'h24) trap(k, 2'b10);
            else q.push_back(v(k, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 6, 0));
        end else if (op == 0 && fn == 6'h08) begin
            q.push_back(v(k, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1));
        end else if (op == 0 && fn == 6'h13) begin
            q.push_back(v(k, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        end else if (op == 6'h08 || op == 6'h09) begin
            q.push_back(v(k, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 2, 0, 0, 0));
            if (op == 6'h08 && ov && ovfen(k)) trap(k, 2'b10);
            else q.push_back(v(k, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0));
        end else if (op == 6'h04 || op == 6'h05) begin
            q.push_back(v(k, (op == 6'h04) ? z : !z, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 2));
        end else if (op == 6'h23) begin
            q.push_back(v(k, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 2, 0, 0, 0));
            repeat (l) q.push_back(v(k, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            q.push_back(v(k, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        end else if (op == 6'h2B) begin
            q.push_back(v(k, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 2, 0, 0, 0));
            repeat (l) q.push_back(v(k, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        end else if (op == 6'h02 || op == 6'h03) begin
            if (op == 6'h03) q.push_back(v(k, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0));
            q.push_back(v(k, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        end else begin
            trap(k, 2'b01);
        end
    endtask

    // Called at a falling edge; abort >= 0 stops checking after that cycle of the instruction.
    task automatic run(int k, logic [5:0] op, logic [5:0] fn, bit ov, bit z, int abort);
        op_v[k] = op;
        fn_v[k] = fn;
        ov_v[k] = ov;
        z_v[k]  = z;
        build(k, op, fn, ov, z);
        for (int i = 0; q.size() > 0; i++) begin
            ctl_t e;
            e = q.pop_front();
            @(negedge clk);
            chk($sformatf("u%0d op%02h fn%02h ov%0d z%0d cyc%0d", k, op, fn, ov, z, i), obs[k], e);
            if (i == abort) q.delete();
        end
    endtask

    task automatic do_reset(int k, int n);
        rst_v[k] = 1'b1;
        exc_m[k] = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("u%0d reset cyc%0d", k, i), obs[k], v(k, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0));
        end
        rst_v[k] = 1'b0;
    endtask

    logic [5:0] rop [15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h04,
                             6'h05, 6'h23, 6'h2B, 6'h02, 6'h03, 6'h3F, 6'h00};
    logic [5:0] rfn [15] = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h13, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21};

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1;
            op_v[k]  = 6'h00;
            fn_v[k]  = 6'h00;
            ov_v[k]  = 1'b0;
            z_v[k]   = 1'b0;
            exc_m[k] = 2'b00;
        end
        for (int k = 0; k < 3; k++) begin
            do_reset(k, 3);
            run(k, 6'h00, 6'h20, 0, 0, -1);
            run(k, 6'h08, 6'h00, 1, 0, -1);
            run(k, 6'h09, 6'h00, 1, 0, -1);
            run(k, 6'h04, 6'h00, 0, 1, -1);
            run(k, 6'h04, 6'h00, 0, 0, -1);
            run(k, 6'h05, 6'h00, 0, 0, -1);
            run(k, 6'h05, 6'h00, 0, 1, -1);
            run(k, 6'h2B, 6'h00, 0, 0, -1);
            run(k, 6'h23, 6'h00, 0, 0, -1);
            run(k, 6'h3F, 6'h00, 0, 0, -1);
            run(k, 6'h03, 6'h00, 0, 0, -1);
            run(k, 6'h02, 6'h00, 0, 0, -1);
            run(k, 6'h00, 6'h08, 0, 0, -1);
            run(k, 6'h00, 6'h13, 0, 0, -1);
            run(k, 6'h00, 6'h22, 1, 0, -1);
            run(k, 6'h00, 6'h24, 1, 0, -1);
            run(k, 6'h00, 6'h20, 1, 1, -1);
            for (int n = 0; n < 30; n++) begin
                int s;
                logic [5:0] op, fn;
                s  = $urandom_range(0, 15);
                op = (s == 15) ? 6'($urandom_range(0, 63)) : rop[s];
                fn = (s == 15 || op != 6'h00) ? 6'($urandom_range(0, 63)) : rfn[s];
                run(k, op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            end
            if (k == 1) begin
                run(k, 6'h3F, 6'h00, 0, 0, -1);
                run(k, 6'h2B, 6'h00, 0, 0, 6);
                do_reset(k, 2);
                run(k, 6'h00, 6'h24, 0, 0, -1);
            end
            rst_v[k] = 1'b1;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
